// File: rtl/exe_stage.sv
// ARM execute stage: Val2 shifter, ALU, NZCV status register and EX/MEM pipeline register.
// Build option EXE_FWD_EN adds forwarding muxes on the Rn/Rm operands.
module exe_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic [3:0]        exe_cmd,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [23:0]       signed_imm24,
    input  logic [3:0]        dest_in,
    input  logic              c_in,
`ifdef EXE_FWD_EN
    input  logic [1:0]        sel_src1,
    input  logic [1:0]        sel_src2,
    input  logic [DATA_W-1:0] mem_fwd_val,
    input  logic [DATA_W-1:0] wb_fwd_val,
`endif
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] st_data_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        sr_out,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_addr
);

    localparam int MSB = DATA_W - 1;

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] st_data;
        logic [3:0]        dest;
    } exmem_t;

    exmem_t            exmem;
    logic [3:0]        sr;
    logic [DATA_W-1:0] op1, op_rm;

`ifdef EXE_FWD_EN
    always_comb begin
        case (sel_src1)
            2'b01:   op1 = mem_fwd_val;
            2'b10:   op1 = wb_fwd_val;
            default: op1 = val1;
        endcase
        case (sel_src2)
            2'b01:   op_rm = mem_fwd_val;
            2'b10:   op_rm = wb_fwd_val;
            default: op_rm = val_rm;
        endcase
    end
`else
    assign op1   = val1;
    assign op_rm = val_rm;
`endif

    // Rotates are built from two shifts; a left shift by the full width yields 0,
    // so a rotate amount of 0 falls out naturally.
    logic [4:0]        sh_amt, rot_amt;
    logic [5:0]        sh_back, rot_back;
    logic [DATA_W-1:0] imm8, imm_rot, rm_ror, val2;

    assign sh_amt   = shift_operand[11:7];
    assign rot_amt  = {shift_operand[11:8], 1'b0};
    assign sh_back  = 6'(DATA_W) - {1'b0, sh_amt};
    assign rot_back = 6'(DATA_W) - {1'b0, rot_amt};
    assign imm8     = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
    assign imm_rot  = (imm8 >> rot_amt) | (imm8 << rot_back);
    assign rm_ror   = (op_rm >> sh_amt) | (op_rm << sh_back);

    always_comb begin
        if (mem_r_en_in | mem_w_en_in)
            val2 = {{(DATA_W-12){1'b0}}, shift_operand};
        else if (imm)
            val2 = imm_rot;
        else begin
            case (shift_operand[6:5])
                2'b00:   val2 = op_rm << sh_amt;
                2'b01:   val2 = op_rm >> sh_amt;
                2'b10:   val2 = $unsigned($signed(op_rm) >>> sh_amt);
                default: val2 = rm_ror;
            endcase
        end
    end

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] res;
    logic              c_flag, v_flag;

    // Subtract carry is NOT borrow; non-arithmetic ops keep the old C and V.
    always_comb begin
        sum    = '0;
        res    = '0;
        c_flag = sr[1];
        v_flag = sr[0];
        case (exe_cmd)
            4'b0001: res = val2;
            4'b1001: res = ~val2;
            4'b0010, 4'b0011: begin
                sum    = {1'b0, op1} + {1'b0, val2} + {{DATA_W{1'b0}}, exe_cmd[0] & c_in};
                res    = sum[MSB:0];
                c_flag = sum[DATA_W];
                v_flag = (op1[MSB] == val2[MSB]) && (res[MSB] != op1[MSB]);
            end
            4'b0100, 4'b0101: begin
                sum    = {1'b0, op1} - {1'b0, val2} - {{DATA_W{1'b0}}, exe_cmd[0] & ~c_in};
                res    = sum[MSB:0];
                c_flag = ~sum[DATA_W];
                v_flag = (op1[MSB] != val2[MSB]) && (res[MSB] != op1[MSB]);
            end
            4'b0110: res = op1 & val2;
            4'b0111: res = op1 | val2;
            4'b1000: res = op1 ^ val2;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exmem <= '0;
            sr    <= '0;
        end else if (!freeze) begin
            exmem <= '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                       alu_res: res, st_data: op_rm, dest: dest_in};
            if (s_in)
                sr <= {res[MSB], res == '0, c_flag, v_flag};
        end
    end

    assign wb_en_out    = exmem.wb_en;
    assign mem_r_en_out = exmem.mem_r_en;
    assign mem_w_en_out = exmem.mem_w_en;
    assign alu_res_out  = exmem.alu_res;
    assign st_data_out  = exmem.st_data;
    assign dest_out     = exmem.dest;
    assign sr_out       = sr;

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{(DATA_W-26){signed_imm24[23]}}, signed_imm24, 2'b00};

endmodule
